// File: rtl/bp_update_arbiter_pkg.sv
// Shared definitions for the branch-predictor update path.
// Entry layout, default queue depth and source IDs live here.
package bp_defs;
  localparam int BP_ENTRY_W = 33;
  localparam int BP_DEPTH = 4;
  localparam int BP_PTR_W = 2;
  localparam int BP_IDX_W = 10;
  localparam logic BP_SRC_ROB = 1'b0;
  localparam logic BP_SRC_EX = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic taken;
  } bp_entry_t;
endpackage

// File: rtl/bp_update_arbiter_if.sv
// Producer-side handshakes for the RoB commit and ALU resolution
// update ports; master = producers, slave = arbiter.
interface bp_update_arbiter_if;
  logic rob_upd_valid;
  logic [31:0] rob_upd_pc;
  logic rob_upd_taken;
  logic rob_upd_ready;
  logic ex_upd_valid;
  logic [31:0] ex_upd_pc;
  logic ex_upd_taken;
  logic ex_upd_ready;

  modport master (
    output rob_upd_valid, rob_upd_pc, rob_upd_taken,
    output ex_upd_valid, ex_upd_pc, ex_upd_taken,
    input rob_upd_ready, ex_upd_ready
  );

  modport slave (
    input rob_upd_valid, rob_upd_pc, rob_upd_taken,
    input ex_upd_valid, ex_upd_pc, ex_upd_taken,
    output rob_upd_ready, ex_upd_ready
  );
endinterface

// File: rtl/bp_update_fifo.sv
// Dual-push, single-pop circular buffer with occupancy count and clear.
// When both pushes fire, slot 0 lands at tail and slot 1 at tail+1.
module bp_update_fifo
  import bp_defs::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push0,
  input  bp_entry_t data0,
  input  logic push1,
  input  bp_entry_t data1,
  input  logic pop,
  output bp_entry_t head_data,
  output logic [PTR_W:0] count
);

  bp_entry_t mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail1;
  logic [1:0] npush;

  assign npush = {1'b0, push0} + {1'b0, push1};
  assign tail1 = tail + PTR_W'(push0);
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (push0) mem[tail] <= data0;
    if (push1) mem[tail1] <= data1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      tail <= tail + PTR_W'(npush);
      if (pop) head <= head + PTR_W'(1);
      count <= count + (PTR_W+1)'(npush)
             - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: rtl/bp_update_arbiter.sv
// Merges RoB and ALU branch outcomes into the predictor update port.
// Optional counters: define BP_UPDATE_STATS_EN.
module bp_update_arbiter
  import bp_defs::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_in,
  bp_update_arbiter_if.slave upd,
  output logic update_en,
  output logic [31:0] update_PC,
  output logic update_result,
  output logic busy
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_drops
`endif
);

  logic [PTR_W:0] count;
  logic [PTR_W:0] free;
  logic run;
  logic clr;
  logic pop;
  logic push0;
  logic push1;
  logic rob_ready;
  logic ex_ready;
  bp_entry_t head_data;
  bp_entry_t rob_data;
  bp_entry_t ex_data;

  // Free space ignores a same-cycle pop to keep ready off the pop path.
  assign free = (PTR_W+1)'(DEPTH) - count;
  assign run = rdy_in & ~flush_in;
  assign clr = rdy_in & flush_in;
  assign pop = run & (count != '0);

  assign rob_ready = run & (free >= (PTR_W+1)'(1));
  assign ex_ready = run
    & ((free >= (PTR_W+1)'(2))
      | ((free == (PTR_W+1)'(1)) & ~upd.rob_upd_valid));

  assign upd.rob_upd_ready = rob_ready;
  assign upd.ex_upd_ready = ex_ready;

  assign push0 = upd.rob_upd_valid & rob_ready;
  assign push1 = upd.ex_upd_valid & ex_ready;
  assign rob_data = '{pc: upd.rob_upd_pc, taken: upd.rob_upd_taken};
  assign ex_data = '{pc: upd.ex_upd_pc, taken: upd.ex_upd_taken};

  bp_update_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk(clk_in),
    .rst(rst_in),
    .clr(clr),
    .push0(push0),
    .data0(rob_data),
    .push1(push1),
    .data1(ex_data),
    .pop(pop),
    .head_data(head_data),
    .count(count)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      update_en <= 1'b0;
      update_PC <= '0;
      update_result <= 1'b0;
    end else if (pop) begin
      update_en <= 1'b1;
      update_PC <= head_data.pc;
      update_result <= head_data.taken;
    end else begin
      update_en <= 1'b0;
    end
  end

  assign busy = (count != '0) | update_en;

`ifdef BP_UPDATE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_updates <= '0;
      stat_taken <= '0;
      stat_drops <= '0;
    end else begin
      if (update_en) stat_updates <= stat_updates + 32'd1;
      if (update_en & update_result) stat_taken <= stat_taken + 32'd1;
      if (clr) stat_drops <= stat_drops + 32'(count);
    end
  end
`endif

endmodule
